// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses a big-endian length/payload/checksum
// stream, writes each 32-bit word to imem and releases the core once the image verifies.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    len_d      = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d      = {len_q[23:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if ((len_d == 32'd0) || (len_d > 32'(MAX_WORDS))) begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                        end else begin
                            state_d    = S_DATA;
                            word_idx_d = '0;
                            csum_d     = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d     = {word_q[15:0], in_data};
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Write lands one cycle after the last byte; stream keeps flowing.
                        imem_we_d    = 1'b1;
                        imem_addr_d  = BASE_ADDR + (word_idx_q << 2);
                        imem_wdata_d = {word_q, in_data};
                        word_idx_d   = word_idx_q + 32'd1;
                        if (word_idx_q == len_q - 32'd1) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (different BASE_ADDR) share one byte stream and are
// checked against a queue-based model of the image format.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready0, imem_we0, cpu_hold0, done0, error0;
    logic [31:0] imem_addr0, imem_wdata0;
    logic        in_ready1, imem_we1, cpu_hold1, done1, error1;
    logic [31:0] imem_addr1, imem_wdata1;

    localparam logic [31:0] BASE1 = 32'h0040_0000;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
    logic [31:0] img_words[$];

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0),
        .imem_wdata(imem_wdata0), .cpu_hold(cpu_hold0), .done(done0), .error(error0));

    imem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(256)) dut1 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1),
        .imem_wdata(imem_wdata1), .cpu_hold(cpu_hold1), .done(done1), .error(error1));

    always @(negedge clk) begin
        if (imem_we0) begin wa0.push_back(imem_addr0); wd0.push_back(imem_wdata0); end
        if (imem_we1) begin wa1.push_back(imem_addr1); wd1.push_back(imem_wdata1); end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        @(negedge clk);
        in_data = b; in_valid = 1'b1;
        while (!in_ready0 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom);
        if (gap) begin @(posedge clk); #1; end
    endtask

    // Drives one full image (uses img_words) and checks the model's predicted outcome.
    task automatic run_image(input string name, input logic [31:0] n, input bit corrupt,
                             input logic [7:0] flip, input bit gap);
        logic [7:0] x, cs;
        bit exp_done;
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        pulse_start();
        n_cmp++;
        if (cpu_hold0 !== 1'b1 || done0 !== 1'b0 || error0 !== 1'b0 || cpu_hold1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_start: hold=%b done=%b err=%b required hold=1 done=0 err=0",
                     name, cpu_hold0, done0, error0);
        end
        for (int i = 0; i < 4; i++) send_byte(n[31-8*i -: 8], gap);
        if (n == 0 || n > 256) begin
            n_cmp++;
            if (error0 !== 1'b1 || error1 !== 1'b1 || done0 !== 1'b0 || in_ready0 !== 1'b0) begin
                n_fail++;
                $display("FAIL %s bad_len: err=%b/%b done=%b rdy=%b required err=1 done=0 rdy=0",
                         name, error0, error1, done0, in_ready0);
            end
            repeat (3) @(posedge clk); #1;
            n_cmp++;
            if (wa0.size() != 0 || wa1.size() != 0) begin
                n_fail++;
                $display("FAIL %s bad_len_writes: got %0d required 0", name, wa0.size());
            end
            return;
        end
        x = 8'h00;
        for (int k = 0; k < int'(n); k++)
            for (int b = 0; b < 4; b++) begin
                x ^= img_words[k][31-8*b -: 8];
                send_byte(img_words[k][31-8*b -: 8], gap);
            end
        cs = corrupt ? (x ^ flip) : x;
        exp_done = (cs == x);
        send_byte(cs, gap);
        n_cmp++;
        if (done0 !== exp_done || error0 !== !exp_done || cpu_hold0 !== !exp_done ||
            done1 !== exp_done || error1 !== !exp_done || cpu_hold1 !== !exp_done) begin
            n_fail++;
            $display("FAIL %s status: done=%b err=%b hold=%b required done=%b err=%b hold=%b",
                     name, done0, error0, cpu_hold0, exp_done, !exp_done, !exp_done);
        end
        n_cmp++;
        if (wa0.size() != int'(n) || wa1.size() != int'(n)) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d/%0d required %0d", name, wa0.size(),
                     wa1.size(), n);
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                n_cmp++;
                if (wa0[k] !== 32'(4*k) || wd0[k] !== img_words[k] ||
                    wa1[k] !== BASE1 + 32'(4*k) || wd1[k] !== img_words[k]) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: addr=%h/%h data=%h required addr=%h/%h data=%h",
                             name, k, wa0[k], wa1[k], wd0[k], 32'(4*k), BASE1 + 32'(4*k),
                             img_words[k]);
                end
            end
        end
    endtask

    task automatic set_three_word();
        img_words = '{32'h2008_0001, 32'h2009_0001, 32'h0109_5020};
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (in_ready0 !== 1'b0 || imem_we0 !== 1'b0 || imem_addr0 !== 32'h0 ||
            imem_addr1 !== BASE1 || imem_wdata0 !== 32'h0 || cpu_hold0 !== 1'b1 ||
            done0 !== 1'b0 || error0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b we=%b addr=%h/%h wd=%h hold=%b done=%b err=%b",
                     in_ready0, imem_we0, imem_addr0, imem_addr1, imem_wdata0, cpu_hold0,
                     done0, error0);
        end
        // Bytes offered while idle must not be consumed.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 8'hA5;
        end
        @(posedge clk); #1; in_valid = 1'b0;
    endtask

    task automatic test_three_word();
        set_three_word();
        run_image("three_word", 32'd3, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_gapped();
        set_three_word();
        run_image("gapped", 32'd3, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_bad_csum();
        set_three_word();
        run_image("bad_csum", 32'd3, 1'b1, 8'h39, 1'b0);
    endtask

    task automatic test_bad_len();
        img_words.delete();
        run_image("len_zero", 32'd0, 1'b0, 8'h00, 1'b0);
        run_image("len_257", 32'd257, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        set_three_word();
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
        for (int b = 0; b < 6; b++) send_byte(8'h11 * b[7:0], 1'b0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready0 !== 1'b0 || cpu_hold0 !== 1'b1 || done0 !== 1'b0 || imem_we0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load: rdy=%b hold=%b done=%b we=%b required 0 1 0 0",
                     in_ready0, cpu_hold0, done0, imem_we0);
        end
        @(negedge clk); reset = 1'b0;
        run_image("after_reset", 32'd3, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_restart_one_word();
        img_words = '{32'h0000_0000};
        run_image("restart_one_word", 32'd1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 6);
            img_words.delete();
            for (int k = 0; k < n; k++) img_words.push_back($urandom);
            run_image("random", 32'(n), ($urandom_range(0, 2) == 0),
                      8'($urandom_range(1, 255)), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_three_word();
        test_restart_one_word();
        test_gapped();
        test_bad_csum();
        test_bad_len();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
